// File: rtl/sipo_rx.sv
// Parametrised UART receive deserialiser: oversampled start detection with false-start
// rejection, optional parity, 1/2 stop bits, held output word with valid/ack handshake.
module sipo_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baudTick,
  input  logic                 serialInput,
  input  logic                 readAck,
  output logic [DATA_BITS-1:0] parallelOutput,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 overrunError,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [3:0]             bit_idx_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_err_reg;
  logic                   frm_err_reg;
  logic                   rx_meta_reg;
  logic                   rx_s_reg;
  logic [DATA_BITS-1:0]   data_reg;
  logic                   valid_reg;
  logic                   par_out_reg;
  logic                   frm_out_reg;
  logic                   ovr_reg;

  logic                   last_stop_sample;
  logic                   frm_final;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= serialInput;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign last_stop_sample = baudTick && (state_reg == STOP) &&
                            (cnt_reg == FULL_LAST) && (bit_idx_reg == STOP_LAST);
  assign frm_final        = frm_err_reg | ~rx_s_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      par_out_reg <= 1'b0;
      frm_out_reg <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      if (baudTick) begin
        case (state_reg)
          IDLE: begin
            if (!rx_s_reg) begin
              state_reg <= START;
              cnt_reg   <= '0;
            end
          end
          START: begin
            if (cnt_reg == HALF_LAST) begin
              cnt_reg <= '0;
              if (rx_s_reg) begin
                state_reg <= IDLE;
              end else begin
                state_reg   <= DATA;
                bit_idx_reg <= '0;
                par_err_reg <= 1'b0;
                frm_err_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt_reg == FULL_LAST) begin
              cnt_reg   <= '0;
              shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
              if (bit_idx_reg == DATA_LAST) begin
                bit_idx_reg <= '0;
                state_reg   <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_idx_reg <= bit_idx_reg + 4'd1;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          PARITY: begin
            if (cnt_reg == FULL_LAST) begin
              cnt_reg     <= '0;
              par_err_reg <= ((^shift_reg) ^ rx_s_reg) != 1'(PARITY_ODD);
              state_reg   <= STOP;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          STOP: begin
            if (cnt_reg == FULL_LAST) begin
              cnt_reg     <= '0;
              frm_err_reg <= frm_final;
              if (bit_idx_reg == STOP_LAST) begin
                bit_idx_reg <= '0;
                // A low final stop means break or stuck line: wait for it to recover.
                state_reg   <= rx_s_reg ? IDLE : WAIT_HIGH;
              end else begin
                bit_idx_reg <= bit_idx_reg + 4'd1;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          WAIT_HIGH: begin
            if (rx_s_reg) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end

      // An ack arriving with a new frame frees the holding register for it.
      if (last_stop_sample) begin
        if (!valid_reg || readAck) begin
          data_reg    <= shift_reg;
          par_out_reg <= par_err_reg;
          frm_out_reg <= frm_final;
          valid_reg   <= 1'b1;
          ovr_reg     <= 1'b0;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (readAck && valid_reg) begin
        valid_reg   <= 1'b0;
        par_out_reg <= 1'b0;
        frm_out_reg <= 1'b0;
        ovr_reg     <= 1'b0;
      end
    end
  end

  assign parallelOutput = data_reg;
  assign dataValid      = valid_reg;
  assign parityError    = par_out_reg;
  assign frameError     = frm_out_reg;
  assign overrunError   = ovr_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: three builds (8N1, 8E1, 7N2) driven with directed and
// random frames; a monitor pops the expected word whenever a new word is presented.
module tb_sipo_rx;
  localparam int OS = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       frm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baudTick;
  logic [2:0] line = 3'b111;
  logic [2:0] ack = 3'b000;
  bit         tick_all = 1'b1;

  logic [7:0] po0, po1;
  logic [6:0] po2;
  logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, oe0, oe1, oe2, bz0, bz1, bz2;
  wire  [2:0] dv_all = {dv2, dv1, dv0};
  wire  [2:0] oe_all = {oe2, oe1, oe0};
  wire  [2:0] bz_all = {bz2, bz1, bz0};

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [2:0] held_m = 3'b000;
  logic [2:0] ovr_m = 3'b000;
  logic [2:0] pv = 3'b000;
  logic [2:0] pa = 3'b000;

  sipo_rx u_def (
    .clk(clk), .rst(rst), .baudTick(baudTick), .serialInput(line[0]), .readAck(ack[0]),
    .parallelOutput(po0), .dataValid(dv0), .parityError(pe0), .frameError(fe0),
    .overrunError(oe0), .busy(bz0));

  sipo_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .baudTick(baudTick), .serialInput(line[1]), .readAck(ack[1]),
    .parallelOutput(po1), .dataValid(dv1), .parityError(pe1), .frameError(fe1),
    .overrunError(oe1), .busy(bz1));

  sipo_rx #(.DATA_BITS(7), .STOP_BITS(2)) u_7b2 (
    .clk(clk), .rst(rst), .baudTick(baudTick), .serialInput(line[2]), .readAck(ack[2]),
    .parallelOutput(po2), .dataValid(dv2), .parityError(pe2), .frameError(fe2),
    .overrunError(oe2), .busy(bz2));

  always #5 clk = ~clk;

  function automatic int db(int i);    return (i == 2) ? 7 : 8; endfunction
  function automatic bit pe_en(int i); return (i == 1);         endfunction
  function automatic int sb(int i);    return (i == 2) ? 2 : 1; endfunction

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(int i, exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Baud tick: every clock in directed tests, irregular in random tests.
  initial begin
    baudTick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baudTick = tick_all || ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_ticks(int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (baudTick) c++;
    end
    #1;
  endtask

  // One frame on line i; stops bit s = level of stop bit s. abort3 resets after 3 data bits.
  task automatic send(int i, int data, int pbit, int stops, int hold, int idle,
                      bit ack_dlv, bit abort3);
    int         n = db(i);
    logic [8:0] dm;
    exp_t       e;
    dm = 9'(data) & 9'((1 << n) - 1);
    if (!abort3) begin
      e.data = dm;
      e.par  = pe_en(i) ? ((^dm) ^ pbit[0]) : 1'b0;
      e.frm  = 1'b0;
      for (int s = 0; s < sb(i); s++) if (!stops[s]) e.frm = 1'b1;
      if (!held_m[i] || ack_dlv) begin
        qpush(i, e);
        held_m[i] = 1'b1;
        ovr_m[i]  = 1'b0;
      end else begin
        ovr_m[i] = 1'b1;
      end
    end
    line[i] = 1'b0;
    wait_ticks(OS);
    for (int k = 0; k < n; k++) begin
      if (abort3 && k == 3) begin
        rst     = 1'b0;
        line[i] = 1'b1;
        held_m  = 3'b000;
        ovr_m   = 3'b000;
        q0.delete(); q1.delete(); q2.delete();
        return;
      end
      line[i] = dm[k];
      wait_ticks(OS);
    end
    if (pe_en(i)) begin
      line[i] = pbit[0];
      wait_ticks(OS);
    end
    for (int s = 0; s < sb(i); s++) begin
      line[i] = stops[s];
      wait_ticks(OS);
    end
    if (hold > 0) begin
      line[i] = 1'b0;
      wait_ticks(hold * OS);
    end
    if (idle > 0) begin
      line[i] = 1'b1;
      wait_ticks(idle * OS);
    end
  endtask

  task automatic do_ack(int i);
    ack[i] = 1'b1;
    @(posedge clk);
    #1;
    ack[i] = 1'b0;
    if (held_m[i]) begin
      held_m[i] = 1'b0;
      ovr_m[i]  = 1'b0;
    end
  endtask

  // Monitor: a new word is presented when dataValid rises or is reloaded under an ack.
  initial begin
    exp_t       e;
    logic [8:0] act_d;
    logic       act_p, act_f;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dv_all[i] && (!pv[i] || pa[i])) begin
          case (i)
            0:       begin act_d = {1'b0, po0}; act_p = pe0; act_f = fe0; end
            1:       begin act_d = {1'b0, po1}; act_p = pe1; act_f = fe1; end
            default: begin act_d = {2'b00, po2}; act_p = pe2; act_f = fe2; end
          endcase
          checks++;
          if (qsize(i) == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected word: got data=%0h par=%0b frm=%0b, expected none",
                     i, act_d, act_p, act_f);
          end else begin
            e = qpop(i);
            if ({act_d, act_p, act_f} != {e.data, e.par, e.frm}) begin
              errors++;
              $display("FAIL dut%0d word: got data=%0h par=%0b frm=%0b, expected data=%0h par=%0b frm=%0b",
                       i, act_d, act_p, act_f, e.data, e.par, e.frm);
            end else begin
              $display("dut%0d rx data=%0h par=%0b frm=%0b", i, act_d, act_p, act_f);
            end
          end
        end
        pv[i] = dv_all[i];
        pa[i] = ack[i];
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Delivery edge counted from the start-bit drive with a tick every clock:
    // 2 sync + 1 detect + half bit + one full bit per data/stop bit.
    int d_exact = 3 + OS / 2 + OS * (8 + 1);
    int d, pb, st, idle;

    repeat (3) @(posedge clk);
    #1;
    check("reset dataValid", dv_all, 0);
    check("reset busy", bz_all, 0);
    check("reset overrun", oe_all, 0);
    check("reset po0", po0, 0);
    check("reset flags0", {pe0, fe0}, 0);
    rst = 1'b1;
    wait_ticks(OS);

    send(0, 'hA5, 0, 1, 0, 1, 1'b0, 1'b0);
    check("A5 dataValid", dv0, 1);
    check("A5 flags", {pe0, fe0, oe0}, 0);
    check("A5 busy after stop", bz0, 0);
    do_ack(0);
    check("A5 ack clears valid", dv0, 0);

    line[0] = 1'b0;
    wait_ticks(4);
    line[0] = 1'b1;
    wait_ticks(2);
    check("glitch busy", bz0, 1);
    wait_ticks(OS);
    check("glitch back to idle", bz0, 0);
    check("glitch no data", dv0, 0);
    send(0, 'h3C, 0, 1, 0, 1, 1'b0, 1'b0);
    check("3C after glitch", po0, 'h3C);
    do_ack(0);

    send(0, 'h81, 0, 0, 2, 0, 1'b0, 1'b0);
    check("81 frameError", fe0, 1);
    check("81 wait_high busy", bz0, 1);
    check("81 dataValid", dv0, 1);
    line[0] = 1'b1;
    wait_ticks(OS);
    check("81 busy after rise", bz0, 0);
    do_ack(0);
    send(0, 'h55, 0, 1, 0, 1, 1'b0, 1'b0);
    check("55 frameError", fe0, 0);
    do_ack(0);

    send(0, 'h11, 0, 1, 0, 1, 1'b0, 1'b0);
    send(0, 'h22, 0, 1, 0, 1, 1'b0, 1'b0);
    check("overrun set", oe0, 1);
    check("overrun keeps word", po0, 'h11);
    do_ack(0);
    check("ack clears all", {dv0, pe0, fe0, oe0}, 0);
    send(0, 'h22, 0, 1, 0, 1, 1'b0, 1'b0);
    fork
      send(0, 'h33, 0, 1, 0, 1, 1'b1, 1'b0);
      begin
        repeat (d_exact - 1) @(posedge clk);
        #1;
        ack[0] = 1'b1;
        @(posedge clk);
        #1;
        ack[0] = 1'b0;
      end
    join
    check("ack on delivery word", po0, 'h33);
    check("ack on delivery valid", dv0, 1);
    check("ack on delivery no overrun", oe0, 0);

    send(0, 'hF0, 0, 1, 0, 0, 1'b0, 1'b1);
    #1;
    check("mid-frame reset po0", po0, 0);
    check("mid-frame reset valid", dv_all, 0);
    check("mid-frame reset busy", bz_all, 0);
    check("mid-frame reset flags", {pe0, fe0, oe0}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ticks(OS);
    send(0, 'h0F, 0, 1, 0, 1, 1'b0, 1'b0);
    check("0F after reset", po0, 'h0F);
    do_ack(0);

    send(1, 'h3C, 1, 1, 0, 1, 1'b0, 1'b0);
    check("bad parity flag", pe1, 1);
    do_ack(1);
    send(1, 'h3C, 0, 1, 0, 1, 1'b0, 1'b0);
    check("good parity flag", pe1, 0);
    do_ack(1);

    send(2, 'h5A, 0, 3, 0, 1, 1'b0, 1'b0);
    check("7N2 word", po2, 'h5A);
    do_ack(2);

    tick_all = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int f = 0; f < 12; f++) begin
        d    = int'($urandom_range(0, 511)) & ((1 << db(i)) - 1);
        pb   = ($countones(d) % 2) ^ (($urandom_range(0, 4) == 0) ? 1 : 0);
        st   = 0;
        for (int s = 0; s < 2; s++) if ($urandom_range(0, 6) != 0) st = st | (1 << s);
        idle = int'($urandom_range(1, 2));
        send(i, d, pb, st, 0, idle, 1'b0, 1'b0);
        check($sformatf("dut%0d random dataValid", i), dv_all[i], held_m[i]);
        check($sformatf("dut%0d random overrun", i), oe_all[i], ovr_m[i]);
        if ($urandom_range(0, 2) != 0) begin
          do_ack(i);
          check($sformatf("dut%0d random ack", i), dv_all[i], 0);
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("dut%0d words outstanding", i), qsize(i), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
